// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, synchronous-read 4x9 BRAM between
// two requesters. At most one access is granted per cycle; read data comes
// back one cycle later and is steered to whichever port issued the read.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter bit FIXED_PRIO_A = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [3:0]            a_wmask,
    input  logic [31:0]           a_wdata,
    input  logic                  a_wgrubby,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [31:0]           a_rdata,
    output logic                  a_rgrubby,

    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [3:0]            b_wmask,
    input  logic [31:0]           b_wdata,
    input  logic                  b_wgrubby,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [31:0]           b_rdata,
    output logic                  b_rgrubby,

    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wgrubby,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rgrubby
);

    // One port's memory command, bundled so the grant mux is a single select.
    typedef struct packed {
        logic                  write;
        logic [3:0]            wmask;
        logic [31:0]           wdata;
        logic                  wgrubby;
        logic [ADDR_WIDTH-1:0] addr;
    } cmd_t;

    cmd_t                  a_cmd, b_cmd, sel_cmd;
    logic                  gnt_any;
    logic                  last_b;
    logic                  rsp_a, rsp_b;
    logic [ADDR_WIDTH-1:0] hold_addr;

    assign a_cmd = '{write: a_write, wmask: a_wmask, wdata: a_wdata,
                     wgrubby: a_wgrubby, addr: a_addr};
    assign b_cmd = '{write: b_write, wmask: b_wmask, wdata: b_wdata,
                     wgrubby: b_wgrubby, addr: b_addr};

    // Grant: A wins alone, under fixed priority, or when B had the last turn;
    // B takes any request A does not. Depends only on req and state, never
    // on returning read data.
    always_comb begin
        a_gnt   = a_req & (~b_req | FIXED_PRIO_A | last_b);
        b_gnt   = b_req & ~a_gnt;
        gnt_any = a_gnt | b_gnt;
        sel_cmd = b_gnt ? b_cmd : a_cmd;
    end

    // Memory command: granted port's fields, or a quiet bus that keeps the
    // previous address so the BRAM output does not change while idle.
    always_comb begin
        mem_write   = 1'b0;
        mem_wmask   = 4'b0;
        mem_wdata   = 32'b0;
        mem_wgrubby = 1'b0;
        mem_addr    = hold_addr;
        if (gnt_any) begin
            // A zero mask is treated as no write at all, not a grubby-only write.
            mem_write   = sel_cmd.write & (|sel_cmd.wmask);
            mem_wmask   = sel_cmd.wmask;
            mem_wdata   = sel_cmd.wdata;
            mem_wgrubby = sel_cmd.wgrubby;
            mem_addr    = sel_cmd.addr;
        end
    end

    // Arbitration history, read-response tracking and the held address.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b    <= 1'b1;
            rsp_a     <= 1'b0;
            rsp_b     <= 1'b0;
            hold_addr <= '0;
        end else begin
            if (gnt_any)
                last_b <= b_gnt;
            rsp_a     <= a_gnt & ~a_write;
            rsp_b     <= b_gnt & ~b_write;
            hold_addr <= mem_addr;
        end
    end

    // Read data is broadcast; valid and the tag qualify which port owns it.
    always_comb begin
        a_rvalid  = rsp_a;
        b_rvalid  = rsp_b;
        a_rdata   = mem_rdata;
        b_rdata   = mem_rdata;
        a_rgrubby = mem_rgrubby & rsp_a;
        b_rgrubby = mem_rgrubby & rsp_b;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven check of the round-robin arbiter against a
// behavioural BRAM, plus a hand-written contention run on a fixed-priority copy.
module tb_mem_arbiter;

    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b0;
    always #5 clk = ~clk;

    // ---------------- round-robin DUT ----------------
    logic          a_req, a_write, a_wgrubby, a_gnt, a_rvalid, a_rgrubby;
    logic [3:0]    a_wmask;
    logic [31:0]   a_wdata, a_rdata;
    logic [AW-1:0] a_addr;
    logic          b_req, b_write, b_wgrubby, b_gnt, b_rvalid, b_rgrubby;
    logic [3:0]    b_wmask;
    logic [31:0]   b_wdata, b_rdata;
    logic [AW-1:0] b_addr;
    logic          mem_write, mem_wgrubby, mem_rgrubby;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO_A(1'b0)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata),
        .a_wgrubby(a_wgrubby), .a_addr(a_addr), .a_gnt(a_gnt),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_rgrubby(a_rgrubby),
        .b_req(b_req), .b_write(b_write), .b_wmask(b_wmask), .b_wdata(b_wdata),
        .b_wgrubby(b_wgrubby), .b_addr(b_addr), .b_gnt(b_gnt),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rgrubby(b_rgrubby),
        .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_wgrubby(mem_wgrubby), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rgrubby(mem_rgrubby)
    );

    // Behavioural 4x9 BRAM: byte-masked write, synchronous read-old.
    logic [31:0] mem_d [0:(1<<AW)-1];
    logic        mem_g [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (load) begin
            mem_d['h10] <= 32'h1234_5678; mem_g['h10] <= 1'b1;
            mem_d['h20] <= 32'h1111_1111; mem_g['h20] <= 1'b0;
            mem_d['h30] <= 32'hAAAA_0030; mem_g['h30] <= 1'b0;
            mem_d['h40] <= 32'hBBBB_0040; mem_g['h40] <= 1'b1;
        end else if (mem_write) begin
            for (int k = 0; k < 4; k++)
                if (mem_wmask[k]) mem_d[mem_addr][k*8 +: 8] <= mem_wdata[k*8 +: 8];
            mem_g[mem_addr] <= mem_wgrubby;
        end
        mem_rdata   <= mem_d[mem_addr];
        mem_rgrubby <= mem_g[mem_addr];
    end

    // ---------------- fixed-priority DUT ----------------
    logic          p_a_req, p_a_gnt, p_a_rvalid, p_a_rgrubby;
    logic [31:0]   p_a_rdata;
    logic [AW-1:0] p_a_addr;
    logic          p_b_req, p_b_gnt, p_b_rvalid, p_b_rgrubby;
    logic [31:0]   p_b_rdata;
    logic [AW-1:0] p_b_addr;
    logic          p_mem_write, p_mem_wgrubby, p_mem_rgrubby;
    logic [3:0]    p_mem_wmask;
    logic [31:0]   p_mem_wdata, p_mem_rdata;
    logic [AW-1:0] p_mem_addr;

    mem_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO_A(1'b1)) dut_p (
        .clk(clk), .rst(rst),
        .a_req(p_a_req), .a_write(1'b0), .a_wmask(4'b0), .a_wdata(32'b0),
        .a_wgrubby(1'b0), .a_addr(p_a_addr), .a_gnt(p_a_gnt),
        .a_rvalid(p_a_rvalid), .a_rdata(p_a_rdata), .a_rgrubby(p_a_rgrubby),
        .b_req(p_b_req), .b_write(1'b0), .b_wmask(4'b0), .b_wdata(32'b0),
        .b_wgrubby(1'b0), .b_addr(p_b_addr), .b_gnt(p_b_gnt),
        .b_rvalid(p_b_rvalid), .b_rdata(p_b_rdata), .b_rgrubby(p_b_rgrubby),
        .mem_write(p_mem_write), .mem_wmask(p_mem_wmask), .mem_wdata(p_mem_wdata),
        .mem_wgrubby(p_mem_wgrubby), .mem_addr(p_mem_addr),
        .mem_rdata(p_mem_rdata), .mem_rgrubby(p_mem_rgrubby)
    );

    // Trivial memory for the priority copy: data echoes the address read.
    always @(posedge clk) begin
        p_mem_rdata   <= {{(32-AW){1'b0}}, p_mem_addr};
        p_mem_rgrubby <= p_mem_addr[0];
    end

    // ---------------- table ----------------
    typedef struct {
        logic [31:0] rst;
        logic [31:0] ar, aw, am, ad, aa;
        logic [31:0] br, bw, bm, bd, ba;
        logic [31:0] eag, ebg;
        logic [31:0] earv, eard, earg;
        logic [31:0] ebrv, ebrd, ebrg;
        logic [31:0] emw, ema;
    } vec_t;

    localparam int NV = 20;
    vec_t vec [NV];

    int n_vec = 0;
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Write grubby tag follows data bit 31 to keep the table narrow.
    task automatic drive(input vec_t v);
        rst       = v.rst[0];
        a_req     = v.ar[0];  a_write = v.aw[0]; a_wmask = v.am[3:0];
        a_wdata   = v.ad;     a_wgrubby = v.ad[31]; a_addr = v.aa[AW-1:0];
        b_req     = v.br[0];  b_write = v.bw[0]; b_wmask = v.bm[3:0];
        b_wdata   = v.bd;     b_wgrubby = v.bd[31]; b_addr = v.ba[AW-1:0];
    endtask

    task automatic check(input int i, input vec_t v);
        chk("a_gnt", i, {31'b0, a_gnt}, v.eag);
        chk("b_gnt", i, {31'b0, b_gnt}, v.ebg);
        chk("a_rvalid", i, {31'b0, a_rvalid}, v.earv);
        chk("a_rgrubby", i, {31'b0, a_rgrubby}, v.earg);
        if (v.earv[0]) chk("a_rdata", i, a_rdata, v.eard);
        chk("b_rvalid", i, {31'b0, b_rvalid}, v.ebrv);
        chk("b_rgrubby", i, {31'b0, b_rgrubby}, v.ebrg);
        if (v.ebrv[0]) chk("b_rdata", i, b_rdata, v.ebrd);
        chk("mem_write", i, {31'b0, mem_write}, v.emw);
        chk("mem_addr", i, {{(32-AW){1'b0}}, mem_addr}, v.ema);
    endtask

    initial begin
        //          rst ar aw am ad            aa      br bw bm ad            ba      ag bg arv ard           arg brv brd           brg mw ma
        vec[0]  = '{0, 0,0,0,0,            0,      0,0,0,0,            0,      0,0, 0,0,            0, 0,0,            0, 0,'h00}; // idle after reset
        vec[1]  = '{0, 1,0,0,0,            'h10,   0,0,0,0,            0,      1,0, 0,0,            0, 0,0,            0, 0,'h10}; // A reads 0x10
        vec[2]  = '{0, 0,0,0,0,            0,      0,0,0,0,            0,      0,0, 1,'h12345678,   1, 0,0,            0, 0,'h10};
        vec[3]  = '{0, 1,0,0,0,            'h30,   1,0,0,0,            'h40,   0,1, 0,0,            0, 0,0,            0, 0,'h40}; // contention, B's turn
        vec[4]  = '{0, 1,0,0,0,            'h30,   1,0,0,0,            'h10,   1,0, 0,0,            0, 1,'hBBBB0040,   1, 0,'h30};
        vec[5]  = '{0, 1,0,0,0,            'h40,   1,0,0,0,            'h10,   0,1, 1,'hAAAA0030,   0, 0,0,            0, 0,'h10};
        vec[6]  = '{0, 1,0,0,0,            'h40,   1,0,0,0,            'h30,   1,0, 0,0,            0, 1,'h12345678,   1, 0,'h40};
        vec[7]  = '{0, 1,0,0,0,            'h10,   1,0,0,0,            'h30,   0,1, 1,'hBBBB0040,   1, 0,0,            0, 0,'h30};
        vec[8]  = '{0, 1,0,0,0,            'h10,   1,1,3,'hDEADBEEF,   'h20,   1,0, 0,0,            0, 1,'hAAAA0030,   0, 0,'h10};
        vec[9]  = '{0, 0,0,0,0,            0,      1,1,3,'hDEADBEEF,   'h20,   0,1, 1,'h12345678,   1, 0,0,            0, 1,'h20}; // B partial write
        vec[10] = '{0, 1,0,0,0,            'h20,   0,0,0,0,            0,      1,0, 0,0,            0, 0,0,            0, 0,'h20}; // no response to write
        vec[11] = '{0, 0,0,0,0,            0,      0,0,0,0,            0,      0,0, 1,'h1111BEEF,   1, 0,0,            0, 0,'h20};
        vec[12] = '{0, 0,0,0,0,            0,      1,1,0,'hFFFFFFFF,   'h30,   0,1, 0,0,            0, 0,0,            0, 0,'h30}; // zero-mask write
        vec[13] = '{0, 1,0,0,0,            'h30,   1,0,0,0,            'h10,   1,0, 0,0,            0, 0,0,            0, 0,'h30}; // last_b moved to B
        vec[14] = '{0, 0,0,0,0,            0,      1,0,0,0,            'h10,   0,1, 1,'hAAAA0030,   0, 0,0,            0, 0,'h10};
        vec[15] = '{0, 0,0,0,0,            0,      0,0,0,0,            0,      0,0, 0,0,            0, 1,'h12345678,   1, 0,'h10};
        vec[16] = '{1, 1,0,0,0,            'h10,   0,0,0,0,            0,      1,0, 0,0,            0, 0,0,            0, 0,'h10}; // read granted under reset
        vec[17] = '{0, 1,0,0,0,            'h40,   1,0,0,0,            'h30,   1,0, 0,0,            0, 0,0,            0, 0,'h40}; // dropped, A wins
        vec[18] = '{0, 0,0,0,0,            0,      1,0,0,0,            'h30,   0,1, 1,'hBBBB0040,   1, 0,0,            0, 0,'h30};
        vec[19] = '{0, 0,0,0,0,            0,      0,0,0,0,            0,      0,0, 0,0,            0, 1,'hAAAA0030,   0, 0,'h30};

        a_req = 0; a_write = 0; a_wmask = 0; a_wdata = 0; a_wgrubby = 0; a_addr = 0;
        b_req = 0; b_write = 0; b_wmask = 0; b_wdata = 0; b_wgrubby = 0; b_addr = 0;
        p_a_req = 0; p_a_addr = 0; p_b_req = 0; p_b_addr = 0;

        rst = 1'b1; load = 1'b1;
        repeat (2) @(posedge clk);
        #1 load = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vec[i]);
            @(negedge clk);
            check(i, vec[i]);
            n_vec++;
            @(posedge clk);
            #1;
        end
        drive(vec[0]);

        // Fixed priority: both request for 6 cycles, A never yields.
        for (int i = 0; i < 6; i++) begin
            p_a_req = 1'b1; p_a_addr = AW'('h100 + i);
            p_b_req = 1'b1; p_b_addr = AW'('h200);
            @(negedge clk);
            chk("p_a_gnt", 100 + i, {31'b0, p_a_gnt}, 32'd1);
            chk("p_b_gnt", 100 + i, {31'b0, p_b_gnt}, 32'd0);
            chk("p_a_rvalid", 100 + i, {31'b0, p_a_rvalid}, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                chk("p_a_rdata", 100 + i, p_a_rdata, 32'h100 + 32'(i - 1));
                chk("p_a_rgrubby", 100 + i, {31'b0, p_a_rgrubby}, 32'((i - 1) & 1));
            end
            chk("p_b_rvalid", 100 + i, {31'b0, p_b_rvalid}, 32'd0);
            n_vec++;
            @(posedge clk);
            #1;
        end
        // A drops; B finally gets its turn.
        p_a_req = 1'b0;
        @(negedge clk);
        chk("p_b_gnt", 106, {31'b0, p_b_gnt}, 32'd1);
        chk("p_a_gnt", 106, {31'b0, p_a_gnt}, 32'd0);
        chk("p_a_rdata", 106, p_a_rdata, 32'h105);
        n_vec++;
        @(posedge clk);
        #1 p_b_req = 1'b0;
        @(negedge clk);
        chk("p_b_rvalid", 107, {31'b0, p_b_rvalid}, 32'd1);
        chk("p_b_rdata", 107, p_b_rdata, 32'h200);
        chk("p_a_rvalid", 107, {31'b0, p_a_rvalid}, 32'd0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported 4x9 BRAM main memory (32-bit data plus grubby tag bit, synchronous read) between two requesters. Typical use: port A is the pipeline's data/instruction side, port B a loader or debug master. The block grants at most one access per cycle, drives the memory command, and routes the one-cycle-late read data back to the port that issued the read.

## Interface
- ADDR_WIDTH, 14, word-address width, matching the memory's `addr`.
- FIXED_PRIO_A, 0, 0 = round-robin between A and B; 1 = A always wins contention.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; command held stable until granted.
- a_write  in  1  1 = write, 0 = read.
- a_wmask  in  4  byte write enables; ignored for reads.
- a_wdata  in  32  write data.
- a_wgrubby  in  1  write grubby tag.
- a_addr  in  ADDR_WIDTH  word address.
- a_gnt  out  1  combinational grant; the command is taken this cycle.
- a_rvalid  out  1  read response valid; asserted the cycle after a granted read.
- a_rdata  out  32  read data; meaningful only when a_rvalid=1.
- a_rgrubby  out  1  read grubby tag, forced to 0 when a_rvalid=0.
- b_*  same set as a_* for port B.
- mem_write  out  1  to memory `write`.
- mem_wmask  out  4  to memory `wmask`.
- mem_wdata  out  32  to memory `wdata`.
- mem_wgrubby  out  1  to memory `wgrubby`.
- mem_addr  out  ADDR_WIDTH  to memory `addr`.
- mem_rdata  in  32  from memory, valid one cycle after the address.
- mem_rgrubby  in  1  from memory, same timing as mem_rdata.

## Operation
- State:
  - `last_b`: 1 = the most recent grant went to B.
  - `rsp_a`, `rsp_b`: response-pending flags.
  - `hold_addr`: last driven address.
- Grant, combinational:
  - Only one port requesting: that port is granted.
  - Both requesting, FIXED_PRIO_A=1: A is granted.
  - Both requesting, round-robin: A is granted if `last_b`=1, otherwise B.
  - Neither requesting: no grant.
- `last_b` updates only in cycles where a grant occurs; it is set to 1 if B was granted, 0 if A was granted.
- Memory command muxes the granted port's fields. mem_write = granted & write & (wmask != 0).
- With no grant:
  - mem_write=0, mem_wmask=0, mem_wdata=0, mem_wgrubby=0.
  - mem_addr = `hold_addr`, so the BRAM output stays stable.
- Response tracking:
  - `rsp_a` <= a_gnt & ~a_write.
  - `rsp_b` <= b_gnt & ~b_write.
  - x_rvalid = `rsp_x`.
  - x_rdata = mem_rdata, passed through.
  - x_rgrubby = mem_rgrubby & `rsp_x`.
- A granted write produces no response.
- Write and read to the same address in consecutive cycles: the read returns the newly written data, because the memory updates before the next read.
- Requester rules:
  - Hold req and the command until gnt.
  - req may drop or change the cycle after gnt.
  - A port may issue a new request while its previous read response is returning.

## Timing
- Reset (rst=1 at a clock edge):
  - `last_b`=1, so A wins the first contention.
  - `rsp_a`=`rsp_b`=0 and `hold_addr`=0.
  - Hence a/b_rvalid=0, a/b_rgrubby=0, mem_addr=0, mem_write=0 in the cycle after reset.
- Gnt outputs are combinational and may be active during reset. The memory command is still driven, but any response is discarded: rst clears `rsp_*`.
- A read response pending when rst asserts is dropped and never presented.
- Latency: grant in cycle N; read data with rvalid in cycle N+1. Throughput is one access per cycle, sustained.
- Contention under round-robin: with both ports requesting continuously, grants alternate A, B, A, B…
- No combinational path from mem_rdata to any gnt.

## Test plan
- Reset, then A reads address 0x0010, which holds 0x1234_5678 with grubby=1 → a_gnt in cycle 0; a_rvalid=1, a_rdata=0x1234_5678, a_rgrubby=1 in cycle 1; b_rvalid stays 0.
- A and B both request reads continuously for 6 cycles, FIXED_PRIO_A=0 → grants A,B,A,B,A,B; each rvalid one cycle later, routed to the correct port with the correct data.
- Same stimulus with FIXED_PRIO_A=1 → a_gnt=1 for all 6 cycles, b_gnt=0, B stalls until A drops req.
- B writes 0xDEAD_BEEF with wmask=4'b0011 to 0x0020 (old value 0x1111_1111), then A reads 0x0020 → a_rdata=0x1111_BEEF; the write produces no b_rvalid.
- A read granted in cycle N and rst asserted at the edge ending cycle N → a_rvalid=0 in cycle N+1; afterwards A wins the first contention.
- Granted write with wmask=0 → mem_write=0, no memory change; `last_b` still updates.
